maze_move_ctrl: RTL

- Sequences player movement through the 40x40 stage wall map.
- On each move request, reads the wall-map cells along the player's leading edge through a one-read-per-cycle lookup port, then commits or rejects the step.
- Sits between the debounced button/direction logic and the VGA draw blocks, which consume pos_x/pos_y.
- The single map-lookup port is owned by this block while busy.

---
 rtl/maze_move_ctrl.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/maze_move_ctrl.sv
// Player movement sequencer: checks the leading edge of the 40x40 wall map, then commits or rejects a step.
// Latency: in-bounds move_done 9 cycles after acceptance (4 reads, 2 cycles each); out-of-bounds reject after 1.
// Backpressure: move_req is dropped while busy or in the move_done cycle; optional MAZE_WRAP_EN wraps columns.
module maze_move_ctrl #(
  parameter int MAP_W   = 40,
  parameter int MAP_H   = 40,
  parameter int P_SIZE  = 4,
  parameter int START_X = 1,
  parameter int START_Y = 1
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       stage_load_i,
  input  logic       move_req_i,
  input  logic [1:0] move_dir_i,
  output logic       map_rd_o,
  output logic [5:0] map_x_o,
  output logic [5:0] map_y_o,
  input  logic       map_wall_i,
  output logic [5:0] pos_x_o,
  output logic [5:0] pos_y_o,
  output logic       busy_o,
  output logic       move_done_o,
  output logic       blocked_o
);

  localparam int KW = (P_SIZE > 1) ? $clog2(P_SIZE) : 1;
  localparam logic signed [6:0] W_S   = 7'(MAP_W);
  localparam logic signed [6:0] H_S   = 7'(MAP_H);
  localparam logic signed [6:0] PM1_S = 7'(P_SIZE - 1);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WAIT, S_DONE} state_t;

  state_t          state_q;
  logic [1:0]      dir_q;
  logic [5:0]      tx_q, ty_q;
  logic [KW-1:0]   k_q;
  logic            rej_q;
  logic            map_rd_q;
  logic [5:0]      map_x_q, map_y_q;
  logic [5:0]      pos_x_q, pos_y_q;
  logic            busy_q, done_q, blocked_q;

  logic signed [6:0] tx_d, ty_d;
  logic              oob_d;
  logic              rej_d;
  logic [11:0]       first_cell, next_cell;

  // Leading-edge cell kk of a footprint whose top-left is (x,y) moving in direction d.
  // The column fold only matters when a wrapped target lets the footprint straddle the right border.
  function automatic logic [11:0] lead_cell(input logic [1:0] d, input logic [5:0] x,
                                            input logic [5:0] y, input logic [KW-1:0] kk);
    logic [6:0] cx;
    logic [5:0] cy;
    cx = {1'b0, x};
    cy = y;
    case (d)
      2'd0:    cx = cx + 7'(kk);
      2'd1:    begin cx = cx + 7'(kk); cy = y + 6'(P_SIZE - 1); end
      2'd2:    cy = y + 6'(kk);
      default: begin cx = cx + 7'(P_SIZE - 1); cy = y + 6'(kk); end
    endcase
    if (cx >= 7'(MAP_W)) cx = cx - 7'(MAP_W);
    return {cx[5:0], cy};
  endfunction

  // Target top-left for the requested direction and its bounds check, in signed 7-bit arithmetic.
  always_comb begin
    tx_d = $signed({1'b0, pos_x_q});
    ty_d = $signed({1'b0, pos_y_q});
    case (move_dir_i)
      2'd0:    ty_d = ty_d - 7'sd1;
      2'd1:    ty_d = ty_d + 7'sd1;
      2'd2:    tx_d = tx_d - 7'sd1;
      default: tx_d = tx_d + 7'sd1;
    endcase
`ifdef MAZE_WRAP_EN
    if (tx_d < 7'sd0)
      tx_d = tx_d + W_S;
    else if (tx_d >= W_S)
      tx_d = tx_d - W_S;
    oob_d = (ty_d < 7'sd0) || (ty_d + PM1_S >= H_S);
`else
    oob_d = (ty_d < 7'sd0) || (ty_d + PM1_S >= H_S) ||
            (tx_d < 7'sd0) || (tx_d + PM1_S >= W_S);
`endif
    first_cell = lead_cell(move_dir_i, tx_d[5:0], ty_d[5:0], '0);
    next_cell  = lead_cell(dir_q, tx_q, ty_q, k_q + KW'(1));
    rej_d      = rej_q | map_wall_i;
  end

  // Move FSM: outputs are registered one state ahead so map_rd/move_done line up with READ/DONE.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      dir_q     <= 2'd0;
      tx_q      <= 6'd0;
      ty_q      <= 6'd0;
      k_q       <= '0;
      rej_q     <= 1'b0;
      map_rd_q  <= 1'b0;
      map_x_q   <= 6'd0;
      map_y_q   <= 6'd0;
      pos_x_q   <= 6'(START_X);
      pos_y_q   <= 6'(START_Y);
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      blocked_q <= 1'b0;
    end else if (stage_load_i) begin
      state_q   <= S_IDLE;
      pos_x_q   <= 6'(START_X);
      pos_y_q   <= 6'(START_Y);
      busy_q    <= 1'b0;
      rej_q     <= 1'b0;
      k_q       <= '0;
      map_rd_q  <= 1'b0;
      done_q    <= 1'b0;
      blocked_q <= 1'b0;
    end else begin
      map_rd_q  <= 1'b0;
      done_q    <= 1'b0;
      blocked_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (move_req_i) begin
            dir_q  <= move_dir_i;
            busy_q <= 1'b1;
            k_q    <= '0;
            tx_q   <= tx_d[5:0];
            ty_q   <= ty_d[5:0];
            if (oob_d) begin
              rej_q     <= 1'b1;
              done_q    <= 1'b1;
              blocked_q <= 1'b1;
              state_q   <= S_DONE;
            end else begin
              rej_q              <= 1'b0;
              map_rd_q           <= 1'b1;
              {map_x_q, map_y_q} <= first_cell;
              state_q            <= S_READ;
            end
          end
        end
        S_READ: state_q <= S_WAIT;
        S_WAIT: begin
          rej_q <= rej_d;
          if (k_q == KW'(P_SIZE - 1)) begin
            done_q    <= 1'b1;
            blocked_q <= rej_d;
            if (!rej_d) begin
              pos_x_q <= tx_q;
              pos_y_q <= ty_q;
            end
            state_q <= S_DONE;
          end else begin
            k_q                <= k_q + KW'(1);
            map_rd_q           <= 1'b1;
            {map_x_q, map_y_q} <= next_cell;
            state_q            <= S_READ;
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign map_rd_o    = map_rd_q;
  assign map_x_o     = map_x_q;
  assign map_y_o     = map_y_q;
  assign pos_x_o     = pos_x_q;
  assign pos_y_o     = pos_y_q;
  assign busy_o      = busy_q;
  // A stage_load landing on the move_done cycle cancels that completion.
  assign move_done_o = done_q & ~stage_load_i;
  assign blocked_o   = blocked_q & ~stage_load_i;

endmodule
